// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Registered, handshaked ALU-select decoder for the RV32 execute stage.
//   Decodes alu_op/opcode/funct7/funct3 into an SEL_W-bit select and holds it
//   (valid/ready) until execute consumes it. Zero-bubble back-to-back issue.
//
//   Build option: define ALU_CTRL_MDU_EN to enable RV32M decode plus the
//   multi-cycle BUSY occupancy path (MUL_LAT / DIV_LAT). Without it, RV32M
//   encodings decode as illegal single-cycle ops and busy is tied low.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               synchronous pipeline kill (drops held op and input)
//   in_valid/in_ready   decode-field handshake (in_ready is combinational)
//   alu_op,opcode,funct7,funct3  instruction decode fields
//   out_valid/out_ready select handshake towards execute
//   alu_sel             registered select, 5-bit codes zero-extended
//   out_multi           held op is an M-extension op
//   out_illegal         held op has no legal decode
//   busy                high while a multi-cycle op occupies the block
module alu_issue_ctrl #(
    parameter int SEL_W   = 5,
    parameter int MUL_LAT = 1,
    parameter int DIV_LAT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [6:0]       opcode,
    input  logic [6:0]       funct7,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] alu_sel,
    output logic             out_multi,
    output logic             out_illegal,
    output logic             busy
);

    localparam logic [4:0] SEL_AND  = 5'b00000;
    localparam logic [4:0] SEL_OR   = 5'b00001;
    localparam logic [4:0] SEL_ADD  = 5'b00010;
    localparam logic [4:0] SEL_XOR  = 5'b00011;
    localparam logic [4:0] SEL_SLL  = 5'b00100;
    localparam logic [4:0] SEL_SRL  = 5'b00101;
    localparam logic [4:0] SEL_SUB  = 5'b00110;
    localparam logic [4:0] SEL_SLTU = 5'b00111;
    localparam logic [4:0] SEL_SLT  = 5'b01000;
    localparam logic [4:0] SEL_SRA  = 5'b01001;
    localparam logic [4:0] SEL_LUI  = 5'b01010;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // Elaboration-time parameter sanity checks.
    if (SEL_W < 5) begin : g_bad_sel_w
        $error("alu_issue_ctrl: SEL_W must be >= 5");
    end
    if (MUL_LAT < 0 || DIV_LAT < 0) begin : g_bad_lat
        $error("alu_issue_ctrl: latencies must be non-negative");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [4:0] d_sel;
    logic       d_multi;
    logic       d_illegal;

    // Shared R/I arithmetic table keyed by {alt, funct3}; alt is funct7[5]
    // for register ops and only meaningful for SUB/SRA.
    function automatic logic [5:0] arith_sel(input logic alt, input logic [2:0] f3);
        // returns {illegal, sel}
        case ({alt, f3})
            4'b0000: arith_sel = {1'b0, SEL_ADD};
            4'b1000: arith_sel = {1'b0, SEL_SUB};
            4'b0001: arith_sel = {1'b0, SEL_SLL};
            4'b0010: arith_sel = {1'b0, SEL_SLT};
            4'b0011: arith_sel = {1'b0, SEL_SLTU};
            4'b0100: arith_sel = {1'b0, SEL_XOR};
            4'b0101: arith_sel = {1'b0, SEL_SRL};
            4'b1101: arith_sel = {1'b0, SEL_SRA};
            4'b0110: arith_sel = {1'b0, SEL_OR};
            4'b0111: arith_sel = {1'b0, SEL_AND};
            default: arith_sel = {1'b1, SEL_ADD};
        endcase
    endfunction

    always_comb begin
        d_sel     = SEL_ADD;
        d_multi   = 1'b0;
        d_illegal = 1'b0;
        case (alu_op)
            2'b00: d_sel = SEL_ADD;
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: d_sel = SEL_SUB;
                    3'b100, 3'b101: d_sel = SEL_SLT;
                    3'b110, 3'b111: d_sel = SEL_SLTU;
                    default:        d_illegal = 1'b1;
                endcase
            end
            2'b10: begin
                if (opcode == OPC_OP) begin
`ifdef ALU_CTRL_MDU_EN
                    if (funct7 == 7'b0000001) begin
                        d_sel   = {2'b10, funct3};
                        d_multi = 1'b1;
                    end else
`endif
                    if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                        {d_illegal, d_sel} = arith_sel(funct7[5], funct3);
                    end else begin
                        d_illegal = 1'b1;
                    end
                end else if (opcode == OPC_OP_IMM) begin
                    // Immediate bits share funct7's slot, so only SRAI/SRLI
                    // look at bit 5; SLLI demands a zero upper field.
                    if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
                        d_illegal = 1'b1;
                    end else begin
                        {d_illegal, d_sel} = arith_sel((funct3 == 3'b101) & funct7[5], funct3);
                    end
                end else begin
                    d_illegal = 1'b1;
                end
            end
            default: d_sel = (opcode == OPC_LUI) ? SEL_LUI : SEL_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign in_ready = (state == IDLE) || (state == VALID && out_ready);

    logic accept;
    assign accept = in_valid && in_ready;

`ifdef ALU_CTRL_MDU_EN
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = ($clog2(MAX_LAT + 1) < 1) ? 1 : $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0] cnt;
    int               d_lat;
    logic             go_busy;

    // funct3[2] splits the M group: 0xx multiplies, 1xx divides/remainders.
    assign d_lat   = funct3[2] ? DIV_LAT : MUL_LAT;
    assign go_busy = d_multi && (d_lat > 0);
`endif

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            alu_sel     <= '0;
            out_multi   <= 1'b0;
            out_illegal <= 1'b0;
            busy        <= 1'b0;
`ifdef ALU_CTRL_MDU_EN
            cnt         <= '0;
`endif
        end else if (flush) begin
            // alu_sel and flags are left as-is; out_valid=0 makes them don't-care.
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef ALU_CTRL_MDU_EN
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE, VALID: begin
                    if (accept) begin
                        alu_sel     <= SEL_W'(d_sel);
                        out_multi   <= d_multi;
                        out_illegal <= d_illegal;
`ifdef ALU_CTRL_MDU_EN
                        if (go_busy) begin
                            cnt       <= CNT_W'(d_lat - 1);
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                            state     <= BUSY;
                        end else begin
                            out_valid <= 1'b1;
                            state     <= VALID;
                        end
`else
                        out_valid <= 1'b1;
                        state     <= VALID;
`endif
                    end else if (state == VALID && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
`ifdef ALU_CTRL_MDU_EN
                BUSY: begin
                    if (cnt == '0) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= VALID;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: decode vector table, hand-written
// stall/flush/reset sequences, then randomized traffic against a
// transaction-level reference model.
module tb_alu_issue_ctrl;

    localparam int SEL_W = 5;
    localparam int MUL_L = 1;
    localparam int DIV_L = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       alu_op = 2'b00;
    logic [6:0]       opcode = 7'b0;
    logic [6:0]       funct7 = 7'b0;
    logic [2:0]       funct3 = 3'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [SEL_W-1:0] alu_sel;
    logic             out_multi;
    logic             out_illegal;
    logic             busy;

    alu_issue_ctrl #(.SEL_W(SEL_W), .MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .opcode(opcode), .funct7(funct7), .funct3(funct3),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_sel(alu_sel), .out_multi(out_multi), .out_illegal(out_illegal),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0] sel;
        logic       multi;
        logic       ill;
    } dec_t;

    localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LUI_OP = 7'b0110111;

`ifdef ALU_CTRL_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    // Mnemonic lookup: returns select code, or -1 for a combination the
    // instruction set does not define.
    function automatic int arith(input bit alt, input logic [2:0] f3);
        int t[16];
        for (int i = 0; i < 16; i++) t[i] = -1;
        t[0]  = 2;  // ADD
        t[8]  = 6;  // SUB
        t[1]  = 4;  // SLL
        t[2]  = 8;  // SLT
        t[3]  = 7;  // SLTU
        t[4]  = 3;  // XOR
        t[5]  = 5;  // SRL
        t[13] = 9;  // SRA
        t[6]  = 1;  // OR
        t[7]  = 0;  // AND
        return t[{alt, f3}];
    endfunction

    function automatic dec_t ref_decode(input logic [1:0] op, input logic [6:0] opc,
                                        input logic [6:0] f7, input logic [2:0] f3);
        dec_t r;
        int   s;
        r = '{sel: 5'd2, multi: 1'b0, ill: 1'b0};
        if (op == 2'd1) begin
            if (f3 inside {3'd0, 3'd1})      r.sel = 5'd6;
            else if (f3 inside {3'd4, 3'd5}) r.sel = 5'd8;
            else if (f3 inside {3'd6, 3'd7}) r.sel = 5'd7;
            else                             r.ill = 1'b1;
        end else if (op == 2'd2) begin
            if (opc == R_OP && MDU && f7 == 7'd1) begin
                r.sel = 5'd16 + 5'(f3);
                r.multi = 1'b1;
            end else if (opc == R_OP && (f7 == 7'd0 || f7 == 7'h20)) begin
                s = arith(f7[5], f3);
                if (s < 0) r.ill = 1'b1; else r.sel = 5'(s);
            end else if (opc == I_OP) begin
                if (f3 == 3'd1 && f7 != 7'd0) r.ill = 1'b1;
                else begin
                    s = arith((f3 == 3'd5) ? f7[5] : 1'b0, f3);
                    r.sel = 5'(s);
                end
            end else begin
                r.ill = 1'b1;
            end
        end else if (op == 2'd3) begin
            if (opc == LUI_OP) r.sel = 5'd10;
        end
        return r;
    endfunction

    // Model state: a held result, and the number of occupancy cycles still
    // owed before a multi-cycle result becomes visible.
    bit       m_vld = 0;
    int       m_left = 0;
    dec_t     m_out = '0;
    bit       chk_rdy = 0;

    task automatic cycle();
        bit   exp_rdy;
        dec_t d;
        int   lat;
        #1;
        exp_rdy = (m_left == 0) && (!m_vld || out_ready);
        if (chk_rdy) chk("in_ready", in_ready, exp_rdy);
        if (rst) begin
            m_vld = 0; m_left = 0; m_out = '0;
        end else if (flush) begin
            m_vld = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_vld = 1;
        end else if (in_valid && exp_rdy) begin
            d = ref_decode(alu_op, opcode, funct7, funct3);
            m_out = d;
            lat = d.multi ? (funct3[2] ? DIV_L : MUL_L) : 0;
            if (lat > 0) begin m_left = lat; m_vld = 0; end
            else m_vld = 1;
        end else if (m_vld && out_ready) begin
            m_vld = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_vld);
        chk("alu_sel", alu_sel, 32'(m_out.sel));
        chk("out_multi", out_multi, m_out.multi);
        chk("out_illegal", out_illegal, m_out.ill);
        chk("busy", busy, m_left > 0);
        chk_rdy = 1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [6:0] opc,
                         input logic [6:0] f7, input logic [2:0] f3);
        alu_op = op; opcode = opc; funct7 = f7; funct3 = f3;
    endtask

    // ---------------- decode vector table ----------------
    typedef struct {
        logic [1:0] op;
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] sel;
        logic       ill;
        logic       multi;
    } vec_t;

    vec_t vt[$];

    initial begin
        int n;
        vt.push_back('{2'b00, 7'b0000011, 7'h00, 3'd2, 5'b00010, 0, 0}); // load
        vt.push_back('{2'b01, 7'b1100011, 7'h00, 3'd0, 5'b00110, 0, 0}); // beq
        vt.push_back('{2'b01, 7'b1100011, 7'h00, 3'd5, 5'b01000, 0, 0}); // bge
        vt.push_back('{2'b01, 7'b1100011, 7'h00, 3'd7, 5'b00111, 0, 0}); // bgeu
        vt.push_back('{2'b01, 7'b1100011, 7'h00, 3'd2, 5'b00010, 1, 0}); // bad branch
        vt.push_back('{2'b10, R_OP,       7'h00, 3'd0, 5'b00010, 0, 0}); // add
        vt.push_back('{2'b10, R_OP,       7'h20, 3'd0, 5'b00110, 0, 0}); // sub
        vt.push_back('{2'b10, R_OP,       7'h20, 3'd5, 5'b01001, 0, 0}); // sra
        vt.push_back('{2'b10, R_OP,       7'h00, 3'd7, 5'b00000, 0, 0}); // and
        vt.push_back('{2'b10, R_OP,       7'h00, 3'd6, 5'b00001, 0, 0}); // or
        vt.push_back('{2'b10, R_OP,       7'h00, 3'd4, 5'b00011, 0, 0}); // xor
        vt.push_back('{2'b10, R_OP,       7'h7f, 3'd0, 5'b00010, 1, 0}); // bad funct7
        vt.push_back('{2'b10, I_OP,       7'h20, 3'd0, 5'b00010, 0, 0}); // addi, not sub
        vt.push_back('{2'b10, I_OP,       7'h20, 3'd5, 5'b01001, 0, 0}); // srai
        vt.push_back('{2'b10, I_OP,       7'h00, 3'd5, 5'b00101, 0, 0}); // srli
        vt.push_back('{2'b10, I_OP,       7'h20, 3'd1, 5'b00010, 1, 0}); // bad slli
        vt.push_back('{2'b11, LUI_OP,     7'h00, 3'd0, 5'b01010, 0, 0}); // lui
        vt.push_back('{2'b11, 7'b1101111, 7'h00, 3'd0, 5'b00010, 0, 0}); // jal
`ifdef ALU_CTRL_MDU_EN
        vt.push_back('{2'b10, R_OP,       7'h01, 3'd0, 5'b10000, 0, 1}); // mul
        vt.push_back('{2'b10, R_OP,       7'h01, 3'd4, 5'b10100, 0, 1}); // div
`else
        vt.push_back('{2'b10, R_OP,       7'h01, 3'd0, 5'b00010, 1, 0}); // mul w/o MDU
`endif

        // Reset for two clocks: everything zero, ready to accept.
        rst = 1; cycle(); cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 0;

        // Table: one op at a time, wait for its result, compare to the row.
        foreach (vt[i]) begin
            drive(vt[i].op, vt[i].opc, vt[i].f7, vt[i].f3);
            in_valid = 1; out_ready = 1;
            cycle();
            in_valid = 0;
            n = 0;
            while (!out_valid && n < 64) begin cycle(); n++; end
            chk("vec_valid", out_valid, 1);
            chk("vec_sel", alu_sel, 32'(vt[i].sel));
            chk("vec_illegal", out_illegal, vt[i].ill);
            chk("vec_multi", out_multi, vt[i].multi);
            cycle();
        end

        // Stall: SUB held while execute refuses, then XOR issued with no bubble.
        drive(2'b10, R_OP, 7'h20, 3'd0); in_valid = 1; out_ready = 1;
        cycle();
        drive(2'b10, R_OP, 7'h00, 3'd4); out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_sel", alu_sel, 32'b00110);
            chk("stall_ready", in_ready, 0);
        end
        out_ready = 1;
        cycle();
        chk("b2b_valid", out_valid, 1);
        chk("b2b_sel", alu_sel, 32'b00011);
        in_valid = 0;
        cycle();

`ifdef ALU_CTRL_MDU_EN
        // DIV occupancy: busy for DIV_L clocks, new input ignored meanwhile,
        // then a flush partway through a second DIV.
        drive(2'b10, R_OP, 7'h01, 3'd4); in_valid = 1;
        cycle();
        drive(2'b10, R_OP, 7'h00, 3'd7);
        n = 0;
        while (!out_valid && n < 64) begin cycle(); n++; end
        chk("div_lat", n, DIV_L);
        chk("div_sel", alu_sel, 32'b10100);
        in_valid = 0; cycle(); cycle();
        drive(2'b10, R_OP, 7'h01, 3'd5); in_valid = 1;
        cycle(); in_valid = 0;
        for (int k = 0; k < 21; k++) cycle();
        flush = 1; in_valid = 1; cycle(); flush = 0; in_valid = 0;
        chk("flush_busy", busy, 0);
        chk("flush_valid", out_valid, 0);
        cycle();
`endif

        // Flush while VALID: held op and the concurrent input both dropped.
        drive(2'b10, R_OP, 7'h00, 3'd0); in_valid = 1;
        cycle();
        flush = 1; drive(2'b11, LUI_OP, 7'h00, 3'd0);
        cycle();
        flush = 0; in_valid = 0;
        chk("flush_vld", out_valid, 0);
        cycle();
        chk("flush_drop", out_valid, 0);

        // Reset while VALID.
        drive(2'b11, LUI_OP, 7'h00, 3'd0); in_valid = 1;
        cycle();
        rst = 1; in_valid = 0;
        cycle();
        chk("rstv_valid", out_valid, 0);
        chk("rstv_sel", alu_sel, 0);
        rst = 0;

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [6:0] opcs[4];
            logic [6:0] f7s[4];
            opcs[0] = R_OP; opcs[1] = I_OP; opcs[2] = LUI_OP; opcs[3] = 7'($urandom);
            f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = 7'($urandom);
            drive(2'($urandom), opcs[$urandom_range(0, 3)], f7s[$urandom_range(0, 3)], 3'($urandom));
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 4);
            rst       = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 0; flush = 0; in_valid = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
